// File: rtl/dmux_8_way_16_buffered_if.sv
// Producer/consumer bundle for the buffered 8-way demultiplexer.
// The slave modport is the demux side; the master modport is the producer plus the lane consumers.
interface dmux_8_way_16_buffered_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0]   in_data;
  logic [2:0]         in_sel;
  logic               in_valid;
  logic               in_ready;
  logic [8*WIDTH-1:0] out_data;
  logic [7:0]         out_valid;
  logic [7:0]         out_ready;
  logic [3:0]         occupancy;

  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_valid, occupancy
  );

  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_valid, occupancy
  );
endinterface

// File: rtl/dmux_8_way_16_buffered.sv
// Registered 8-way demultiplexer: routes one input word into one of eight one-entry
// lane buffers, each drained independently through its own valid/ready handshake.
module dmux_8_way_16_buffered #(
  parameter int WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  dmux_8_way_16_buffered_if.slave   bus
);

  logic [7:0]       valid_q;
  logic [7:0]       valid_d;
  logic [WIDTH-1:0] data_q [8];
  logic [WIDTH-1:0] data_d [8];
  logic [3:0]       occupancy_q;
  logic [3:0]       occupancy_d;
  logic             in_ready;
  logic             in_fire;
  logic [7:0]       load;
  logic [7:0]       drain;

  // A full lane can still accept when its consumer drains it on the same edge.
  // rst_n gates in_ready directly so nothing is accepted while reset is held.
  always_comb begin
    in_ready = rst_n & (~valid_q[bus.in_sel] | bus.out_ready[bus.in_sel]);
    in_fire  = bus.in_valid & in_ready;
  end

  always_comb begin
    load        = '0;
    drain       = '0;
    valid_d     = valid_q;
    occupancy_d = '0;
    for (int i = 0; i < 8; i++) begin
      data_d[i]   = data_q[i];
      load[i]     = in_fire & (bus.in_sel == 3'(i));
      drain[i]    = valid_q[i] & bus.out_ready[i];
      valid_d[i]  = load[i] | (valid_q[i] & ~drain[i]);
      if (load[i]) begin
        data_d[i] = bus.in_data;
      end
      occupancy_d = occupancy_d + 4'(valid_d[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= '0;
      occupancy_q <= '0;
      for (int i = 0; i < 8; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q     <= valid_d;
      occupancy_q <= occupancy_d;
      for (int i = 0; i < 8; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_lane
    assign bus.out_data[WIDTH*gi +: WIDTH] = data_q[gi];
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = valid_q;
  assign bus.occupancy = occupancy_q;

endmodule
